mem_arbiter: RTL

- Arbitrates the single physical memory port between the instruction fetch unit (read-only) and the load/store unit (read/write).
- Sits between IFU/LSU and the pmem interface.
- Serializes requests: exactly one transaction outstanding at a time.
- Routes each response back to its owner; a watchdog terminates any transaction the memory never answers.

---
 rtl/mem_arbiter.sv | 194 +++++++++++++++++++
 1 files changed

// File: rtl/mem_arbiter.sv
// Single-port memory arbiter between instruction fetch (read-only) and load/store.
// Define ARB_RR_EN for round-robin arbitration; otherwise LSU has fixed priority over IFU.
`ifndef CPU_WIDTH
`define CPU_WIDTH 64
`endif

module mem_arbiter #(
    parameter  int TIMEOUT   = 255,
    localparam int CPU_WIDTH = `CPU_WIDTH,
    localparam int CNT_W     = $clog2(TIMEOUT + 1)
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,

    input  logic                 i_ifu_req,
    input  logic [CPU_WIDTH-1:0] i_ifu_addr,
    output logic                 o_ifu_gnt,
    output logic                 o_ifu_rvalid,
    output logic [CPU_WIDTH-1:0] o_ifu_rdata,

    input  logic                 i_lsu_req,
    input  logic                 i_lsu_wen,
    input  logic [CPU_WIDTH-1:0] i_lsu_addr,
    input  logic [CPU_WIDTH-1:0] i_lsu_wdata,
    input  logic [7:0]           i_lsu_wmask,
    output logic                 o_lsu_gnt,
    output logic                 o_lsu_rvalid,
    output logic [CPU_WIDTH-1:0] o_lsu_rdata,

    output logic                 o_mem_req,
    output logic                 o_mem_wen,
    output logic [CPU_WIDTH-1:0] o_mem_addr,
    output logic [CPU_WIDTH-1:0] o_mem_wdata,
    output logic [7:0]           o_mem_wmask,
    input  logic                 i_mem_gnt,
    input  logic                 i_mem_rvalid,
    input  logic [CPU_WIDTH-1:0] i_mem_rdata,

    output logic                 o_err
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_RSP  = 2'd2
    } state_e;

    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT - 1);

    state_e               state_q, state_d;
    logic                 owner_q, owner_d;     // 1 = LSU, 0 = IFU
    logic                 wen_q, wen_d;
    logic [CPU_WIDTH-1:0] addr_q, addr_d;
    logic [CPU_WIDTH-1:0] wdata_q, wdata_d;
    logic [7:0]           wmask_q, wmask_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 grant_ifu;
    logic                 grant_lsu;
    logic                 done;
    logic                 expire;

`ifdef ARB_RR_EN
    logic                 last_q, last_d;       // 1 = LSU won the previous grant

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            last_q <= 1'b0;
        end else begin
            last_q <= last_d;
        end
    end
`endif

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= S_IDLE;
            owner_q <= 1'b0;
            wen_q   <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wmask_q <= '0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            wen_q   <= wen_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            wmask_q <= wmask_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        owner_d   = owner_q;
        wen_d     = wen_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        wmask_d   = wmask_q;
        cnt_d     = cnt_q;
        grant_ifu = 1'b0;
        grant_lsu = 1'b0;
        done      = 1'b0;
        expire    = 1'b0;
`ifdef ARB_RR_EN
        last_d    = last_q;
`endif

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (i_lsu_req && i_ifu_req) begin
`ifdef ARB_RR_EN
                    grant_lsu = ~last_q;
                    grant_ifu = last_q;
`else
                    grant_lsu = 1'b1;
`endif
                end else begin
                    grant_lsu = i_lsu_req;
                    grant_ifu = i_ifu_req;
                end

                // Only stores carry a byte mask; reads always present an empty mask.
                if (grant_lsu) begin
                    owner_d = 1'b1;
                    wen_d   = i_lsu_wen;
                    addr_d  = i_lsu_addr;
                    wdata_d = i_lsu_wdata;
                    wmask_d = i_lsu_wen ? i_lsu_wmask : 8'h00;
                    state_d = S_REQ;
                end else if (grant_ifu) begin
                    owner_d = 1'b0;
                    wen_d   = 1'b0;
                    addr_d  = i_ifu_addr;
                    wdata_d = '0;
                    wmask_d = 8'h00;
                    state_d = S_REQ;
                end
`ifdef ARB_RR_EN
                if (grant_lsu || grant_ifu) begin
                    last_d = grant_lsu;
                end
`endif
            end

            S_REQ: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (i_mem_gnt && i_mem_rvalid) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    expire  = 1'b1;
                    state_d = S_IDLE;
                end else if (i_mem_gnt) begin
                    state_d = S_RSP;
                end
            end

            S_RSP: begin
                cnt_d = cnt_q + CNT_W'(1);
                if (i_mem_rvalid) begin
                    done    = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == TO_LAST) begin
                    expire  = 1'b1;
                    state_d = S_IDLE;
                end
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // A watchdog expiry completes the owner's transaction with zero data plus o_err.
    assign o_ifu_gnt    = grant_ifu;
    assign o_lsu_gnt    = grant_lsu;
    assign o_ifu_rvalid = (done | expire) & ~owner_q;
    assign o_lsu_rvalid = (done | expire) & owner_q;
    assign o_ifu_rdata  = (done & ~owner_q) ? i_mem_rdata : '0;
    assign o_lsu_rdata  = (done & owner_q & ~wen_q) ? i_mem_rdata : '0;
    assign o_err        = expire;

    assign o_mem_req    = (state_q == S_REQ);
    assign o_mem_wen    = wen_q;
    assign o_mem_addr   = addr_q;
    assign o_mem_wdata  = wdata_q;
    assign o_mem_wmask  = wmask_q;

endmodule
